// File: rtl/jtframe_db15_pkg.sv
// Shared types and constants for the SNAC DB15 joystick reader.
package jtframe_db15_pkg;

  // Scan sequencer states; each state lasts one tick, except StDone (one clk)
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSlo,
    StShi,
    StDone
  } state_e;

  // Pin levels while the chain is not being scanned
  localparam logic JoyClkIdle  = 1'b1;
  localparam logic JoyLoadIdle = 1'b1;

endpackage

// File: rtl/jtframe_db15_tick.sv
// Clock divider producing a one-clk tick every CLK_DIV cycles while enabled.
module jtframe_db15_tick #(
  parameter int unsigned CLK_DIV = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Tick on the last count; counter parked at zero while disabled
  always_comb begin
    tick  = en && (cnt_q == CntMax);
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/jtframe_db15_joy.sv
// Serial reader for the SNAC DB15 adaptor: drives the 74HC165 chain and
// publishes one complete, active-high frame of buttons per scan.
module jtframe_db15_joy
  import jtframe_db15_pkg::*;
#(
  parameter int unsigned CLK_DIV = 24,
  parameter int unsigned NBITS   = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode_2p,
  input  logic               joy_data,
  output logic               joy_clk,
  output logic               joy_load,
  output logic [NBITS/2-1:0] joy1,
  output logic [NBITS/2-1:0] joy2,
  output logic               frame_done
);

  localparam int unsigned Half = NBITS / 2;
  localparam int unsigned KW   = $clog2(NBITS);
  localparam logic [KW-1:0] KMax = KW'(NBITS - 1);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [1:0]      sync_q;
  logic            data_sync;
  logic            tick;
  logic [NBITS-1:0] sr_q;
  logic [Half-1:0] p1_word, p2_word;
  logic            joy_clk_q, joy_load_q, frame_done_q;
  logic            joy_clk_d, joy_load_d, frame_done_d;
  logic [Half-1:0] joy1_q, joy2_q;

  jtframe_db15_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  // Two-flop synchroniser; idles high like an unpressed chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], joy_data};
    end
  end

  assign data_sync = sync_q[1];

  // FSM state and bit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic; disabling forces an immediate return to idle
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (!en) begin
      state_d = StIdle;
      k_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: if (tick) state_d = StLoad;
        StLoad: begin
          if (tick) begin
            state_d = StSlo;
            k_d     = '0;
          end
        end
        StSlo: if (tick) state_d = StShi;
        StShi: begin
          if (tick) begin
            if (k_q == KMax) begin
              state_d = StDone;
            end else begin
              k_d     = k_q + 1'b1;
              state_d = StSlo;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Pin and strobe levels derived from the next state so the pins are registered
  always_comb begin
    joy_clk_d    = (state_d == StSlo)  ? 1'b0 : JoyClkIdle;
    joy_load_d   = (state_d == StLoad) ? 1'b0 : JoyLoadIdle;
    frame_done_d = en && (state_q == StDone);
  end

  // Shift register samples the chain at the end of each low half-period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (!en) begin
      sr_q <= '0;
    end else if (state_q == StSlo && tick) begin
      sr_q <= {sr_q[NBITS-2:0], data_sync};
    end
  end

  // Invert and bit-reverse so the first bit received ends up in bit 0
  always_comb begin
    p1_word = '0;
    p2_word = '0;
    for (int i = 0; i < Half; i++) begin
      p1_word[i] = ~sr_q[NBITS-1-i];
      p2_word[i] = ~sr_q[Half-1-i];
    end
  end

  // Output registers; button words only change when a full frame completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      joy_clk_q    <= JoyClkIdle;
      joy_load_q   <= JoyLoadIdle;
      frame_done_q <= 1'b0;
      joy1_q       <= '0;
      joy2_q       <= '0;
    end else begin
      joy_clk_q    <= joy_clk_d;
      joy_load_q   <= joy_load_d;
      frame_done_q <= frame_done_d;
      if (!en) begin
        joy1_q <= '0;
        joy2_q <= '0;
      end else if (state_q == StDone) begin
        joy1_q <= p1_word;
        joy2_q <= mode_2p ? p2_word : '0;
      end
    end
  end

  assign joy_clk    = joy_clk_q;
  assign joy_load   = joy_load_q;
  assign frame_done = frame_done_q;
  assign joy1       = joy1_q;
  assign joy2       = joy2_q;

endmodule

// File: tb/tb_jtframe_db15_joy.sv
// Directed bench for jtframe_db15_joy with a behavioural 24-bit button chain.
module tb_jtframe_db15_joy;
  import jtframe_db15_pkg::*;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned NBITS   = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        mode_2p = 1'b0;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [11:0] joy1;
  logic [11:0] joy2;
  logic        frame_done;

  logic [11:0] p1 = 12'h000;
  logic [11:0] p2 = 12'h000;
  logic [23:0] btn;
  int          pos = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          load_clks = 0;

  jtframe_db15_joy #(
    .CLK_DIV (CLK_DIV),
    .NBITS   (NBITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode_2p    (mode_2p),
    .joy_data   (joy_data),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joy1       (joy1),
    .joy2       (joy2),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Chain model: position resets on load, advances on each rising shift clock.
  // Serial order is P1 bit 0..11 then P2 bit 0..11; pressed buttons read low.
  assign btn = {p2, p1};
  always @(posedge joy_clk or negedge joy_load) begin
    if (!joy_load) pos <= 0;
    else           pos <= pos + 1;
  end
  assign joy_data = (pos < 24) ? ~btn[pos] : 1'b1;

  // Monitors sampled away from the active edge
  always @(negedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (!joy_load)  load_clks <= load_clks + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame_done && n < budget);
  endtask

  task automatic wait_pos(input int target, input int budget, output bit hit);
    int n;
    n = 0;
    while (pos != target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    hit = (pos == target);
  endtask

  initial begin
    int n;
    bit hit;
    int d0;
    int l0;

    // Reset values
    step(3);
    check("rst_joy_clk", joy_clk, 1'b1);
    check("rst_joy_load", joy_load, 1'b1);
    check("rst_joy1", joy1, 12'h000);
    check("rst_joy2", joy2, 12'h000);
    check("rst_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    step(2);

    // 1: no buttons, first frame latency, load width, edge count
    d0 = done_cnt;
    l0 = load_clks;
    en = 1'b1;
    wait_done(400, n);
    check("t1_latency", n, 201);
    check("t1_joy1", joy1, 12'h000);
    check("t1_joy2", joy2, 12'h000);
    check("t1_rises", pos, 24);
    p1 = 12'h005;
    p2 = 12'h800;
    mode_2p = 1'b1;
    step(1);
    check("t1_pulse_width", frame_done, 1'b0);
    step(1);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_load_clks", load_clks - l0, 4);

    // 2: two-player frame
    wait_done(400, n);
    check("t2_done", frame_done, 1'b1);
    check("t2_joy1", joy1, 12'h005);
    check("t2_joy2", joy2, 12'h800);
    check("t2_rises", pos, 24);
    mode_2p = 1'b0;

    // 3: single-player mode masks player 2
    wait_done(400, n);
    check("t3_done", frame_done, 1'b1);
    check("t3_joy1", joy1, 12'h005);
    check("t3_joy2", joy2, 12'h000);
    mode_2p = 1'b1;

    // 4: buttons change after ten bits have been shifted
    wait_pos(10, 400, hit);
    check("t4_reach_bit10", hit, 1'b1);
    check("t4_no_mid_update", joy1, 12'h005);
    check("t4_no_mid_done", frame_done, 1'b0);
    p1 = 12'hFFF;
    wait_done(400, n);
    check("t4_done_mixed", frame_done, 1'b1);
    check("t4_joy1_mixed", joy1, 12'hC05);
    check("t4_joy2_mixed", joy2, 12'h800);
    wait_done(400, n);
    check("t4_done_next", frame_done, 1'b1);
    check("t4_joy1_next", joy1, 12'hFFF);

    // 5: disable mid-frame, then re-enable
    wait_pos(7, 400, hit);
    check("t5_reach_bit7", hit, 1'b1);
    en = 1'b0;
    step(1);
    check("t5_joy_clk", joy_clk, 1'b1);
    check("t5_joy_load", joy_load, 1'b1);
    check("t5_joy1", joy1, 12'h000);
    check("t5_joy2", joy2, 12'h000);
    check("t5_frame_done", frame_done, 1'b0);
    d0 = done_cnt;
    l0 = load_clks;
    step(250);
    check("t5_idle_done", done_cnt - d0, 0);
    check("t5_idle_load", load_clks - l0, 0);
    en = 1'b1;
    wait_done(400, n);
    check("t5_relatency", n, 201);
    check("t5_joy1", joy1, 12'hFFF);
    check("t5_joy2", joy2, 12'h800);

    // 6: asynchronous reset during a low shift-clock phase
    n = 0;
    while (joy_clk !== 1'b0 && n < 400) begin
      step(1);
      n++;
    end
    check("t6_reach_slo", joy_clk, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_joy_clk", joy_clk, 1'b1);
    check("t6_joy_load", joy_load, 1'b1);
    check("t6_joy1", joy1, 12'h000);
    check("t6_joy2", joy2, 12'h000);
    check("t6_frame_done", frame_done, 1'b0);
    check("t6_state", 32'(dut.state_q), 32'(StIdle));
    step(3);
    check("t6_hold_load", joy_load, 1'b1);
    rst_n = 1'b1;
    wait_done(400, n);
    check("t6_relatency", n, 201);
    check("t6_joy1", joy1, 12'hFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
